axi4_stream_downsizer: RTL and testbench
========================================

AXI4_STREAM_DOWNSIZER -- requirements
Module: axi4_stream_downsizer

Interface
REQ-001 Parameter RX_TDATA_WIDTH, default 64, input (wide) tdata width in bits.
REQ-002 Parameter TX_TDATA_WIDTH, default 16, output (narrow) tdata width in bits.
REQ-003 Parameter TID_WIDTH, default 1, tid width.
REQ-004 Parameter TDEST_WIDTH, default 1, tdest width.
REQ-005 Parameter TUSER_WIDTH, default 1, tuser width.
REQ-006 clk_i  input  1  single clock; all logic on rising edge.
REQ-007 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-008 pkt_i  axi4_stream_if.slave  RX_TDATA_WIDTH  wide input stream (tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid, tready).
REQ-009 pkt_o  axi4_stream_if.master  TX_TDATA_WIDTH  narrow output stream, same signal set.

Function
REQ-010 RATIO = RX_TDATA_WIDTH / TX_TDATA_WIDTH; both widths SHALL be multiples of 8 and RATIO an integer >= 2; otherwise elaboration SHALL fail.
REQ-011 Block SHALL hold one wide beat in a holding register (data, keep, strb, last, tid, tdest, tuser) plus a word index idx (width $clog2(RATIO)) and a full flag.
REQ-012 Narrow word k SHALL be bytes [k*TX_B +: TX_B] of the held beat (word 0 = least significant, emitted first); tkeep/tstrb sliced identically.
REQ-013 pkt_o.tvalid SHALL equal full; pkt_o.tdata/tkeep/tstrb SHALL be word idx of the held beat.
REQ-014 tid, tdest, tuser SHALL be driven unchanged on every narrow word of a wide beat.
REQ-015 final word index fin = RATIO-1, except as modified by REQ-027.
REQ-016 pkt_o.tlast SHALL be held tlast AND (idx == fin); no other narrow word SHALL carry tlast.
REQ-017 On pkt_o handshake with idx != fin: idx increments by 1.
REQ-018 On pkt_o handshake with idx == fin: idx returns to 0; full clears unless a new beat is accepted same cycle.
REQ-019 pkt_i.tready SHALL be (!full) OR (pkt_o.tready AND idx == fin) -- zero-bubble; tready SHALL NOT depend on pkt_i.tvalid.
REQ-020 On pkt_i handshake the holding register SHALL load, full SHALL set, idx SHALL be 0.
REQ-021 Latency: beat accepted at edge N SHALL present word 0 on pkt_o in cycle after N; sustained throughput one narrow word per cycle.
REQ-022 Backpressure (pkt_o.tready low) SHALL hold all pkt_o outputs stable while tvalid high.
REQ-023 No combinational path from pkt_i.tdata/tvalid to any pkt_o signal.

Reset
REQ-024 While rst_n_i low: full=0, idx=0, holding register cleared to 0; pkt_o.tvalid=0, pkt_o.tlast=0, pkt_o.tdata/tkeep/tstrb/tid/tdest/tuser=0, pkt_i.tready=1.
REQ-025 Reset mid-beat SHALL discard remaining words; no partial word emitted after release.
REQ-026 First pkt_i handshake possible on first rising edge after rst_n_i deasserts.

Configuration
REQ-027 Macro AXI4_STREAM_DOWNSIZER_TRIM_EN defined: for a held beat with tlast=1, fin SHALL be index of highest narrow word with any tkeep bit set (0 if tkeep all zero); trailing null words are not emitted.
REQ-028 Macro undefined: fin SHALL always be RATIO-1; trailing words of a tlast beat emitted with tkeep=0.
REQ-029 Non-tlast beats SHALL always emit all RATIO words in both configurations.

Structure
REQ-030 Package axi4_stream_downsizer_pkg SHALL hold function ratio_f(rx, tx) and idx_width_f(ratio); no parameter-dependent typedefs.
REQ-031 Sub-module axi4_stream_last_word_finder (combinational, keep vector in, highest non-null word index out) SHALL compute fin under TRIM_EN; instantiated only when macro defined.
REQ-032 Estimated RTL 150-250 lines.

Verification (defaults 64->16)
REQ-033 One beat tdata=0x4444_3333_2222_1111, tkeep=0xFF, tlast=1, tready_o constantly 1 -> words 0x1111,0x2222,0x3333,0x4444 on 4 consecutive cycles, tlast only on 0x4444.
REQ-034 Three back-to-back beats, tvalid constantly 1, tready_o=1 -> 12 words with no idle cycle; pkt_i.tready low 3 of every 4 cycles.
REQ-035 tkeep=0x0F, tlast=1: TRIM_EN -> 2 words, tlast on word 1; undefined -> 4 words, words 2-3 tkeep=0, tlast on word 3.
REQ-036 pkt_o.tready random 50 %, 100 random beats -> output byte stream, tlast positions and per-beat tid/tdest/tuser match model; outputs stable while stalled.
REQ-037 rst_n_i pulsed low while idx=2 -> pkt_o.tvalid=0 during reset; next output is word 0 of next accepted beat.

Source files
------------

// File: rtl/axi4_stream_downsizer_pkg.sv
// Shared helpers for the AXI4-Stream wide-to-narrow downsizer.
// Holds only width arithmetic; no parameter-dependent types live here.
package axi4_stream_downsizer_pkg;

  localparam int BYTE_W = 8;

  function automatic int ratio_f(input int rx, input int tx);
    return (tx > 0) ? (rx / tx) : 0;
  endfunction

  // Keep the word index at least one bit wide so a 2:1 build still has a register.
  function automatic int idx_width_f(input int ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with master/slave views, sized per instance.
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic [KEEP_WIDTH-1:0] tstrb;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid,
                  input  tready);
  modport slave  (input  tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid,
                  output tready);
endinterface

// File: rtl/axi4_stream_last_word_finder.sv
// Finds the highest narrow word whose keep slice has any bit set (0 when all null).
// Only instantiated when AXI4_STREAM_DOWNSIZER_TRIM_EN is defined.
module axi4_stream_last_word_finder
  import axi4_stream_downsizer_pkg::*;
#(
  parameter int KEEP_WIDTH = 8,
  parameter int RATIO      = 4,
  parameter int IDX_W      = 2
) (
  input  logic [KEEP_WIDTH-1:0] keep_i,
  output logic [IDX_W-1:0]      idx_o
);
  localparam int WORD_B = KEEP_WIDTH / RATIO;

  // Later words overwrite earlier ones, so the highest populated word wins.
  always_comb begin
    idx_o = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (|keep_i[k*WORD_B +: WORD_B]) begin
        idx_o = IDX_W'(k);
      end
    end
  end
endmodule

// File: rtl/axi4_stream_downsizer.sv
// Splits each wide AXI4-Stream beat into RATIO narrow words, LSB word first.
// Define AXI4_STREAM_DOWNSIZER_TRIM_EN to drop trailing null words of a tlast beat.
module axi4_stream_downsizer
  import axi4_stream_downsizer_pkg::*;
#(
  parameter int RX_TDATA_WIDTH = 64,
  parameter int TX_TDATA_WIDTH = 16,
  parameter int TID_WIDTH      = 1,
  parameter int TDEST_WIDTH    = 1,
  parameter int TUSER_WIDTH    = 1
) (
  input logic           clk_i,
  input logic           rst_n_i,
  axi4_stream_if.slave  pkt_i,
  axi4_stream_if.master pkt_o
);
  localparam int RATIO = ratio_f(RX_TDATA_WIDTH, TX_TDATA_WIDTH);
  localparam int IDX_W = idx_width_f(RATIO);
  localparam int RX_B  = RX_TDATA_WIDTH / BYTE_W;
  localparam int TX_B  = TX_TDATA_WIDTH / BYTE_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  if ((RX_TDATA_WIDTH % BYTE_W) != 0 || (TX_TDATA_WIDTH % BYTE_W) != 0 ||
      (TX_TDATA_WIDTH <= 0) || (RX_TDATA_WIDTH % TX_TDATA_WIDTH) != 0 || RATIO < 2) begin : gBadWidths
    $error("axi4_stream_downsizer: widths must be byte multiples with an integer ratio >= 2");
  end

  logic [RX_TDATA_WIDTH-1:0] data_q, data_d;
  logic [RX_B-1:0]           keep_q, keep_d;
  logic [RX_B-1:0]           strb_q, strb_d;
  logic                      last_q, last_d;
  logic [TID_WIDTH-1:0]      id_q, id_d;
  logic [TDEST_WIDTH-1:0]    dest_q, dest_d;
  logic [TUSER_WIDTH-1:0]    user_q, user_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      full_q, full_d;

  logic [IDX_W-1:0] finIdx;
  logic             atFin;
  logic             inHs;
  logic             outHs;

  logic [TX_TDATA_WIDTH-1:0] dataWords [RATIO];
  logic [TX_B-1:0]           keepWords [RATIO];
  logic [TX_B-1:0]           strbWords [RATIO];

  for (genvar k = 0; k < RATIO; k++) begin : gWords
    assign dataWords[k] = data_q[k*TX_TDATA_WIDTH +: TX_TDATA_WIDTH];
    assign keepWords[k] = keep_q[k*TX_B +: TX_B];
    assign strbWords[k] = strb_q[k*TX_B +: TX_B];
  end

`ifdef AXI4_STREAM_DOWNSIZER_TRIM_EN
  logic [IDX_W-1:0] trimIdx;

  axi4_stream_last_word_finder #(
    .KEEP_WIDTH (RX_B),
    .RATIO      (RATIO),
    .IDX_W      (IDX_W)
  ) uLastWordFinder (
    .keep_i (keep_q),
    .idx_o  (trimIdx)
  );

  assign finIdx = last_q ? trimIdx : LAST_IDX;
`else
  assign finIdx = LAST_IDX;
`endif

  // Accept a new beat when empty, or in the same cycle the final word leaves.
  assign atFin        = (idx_q == finIdx);
  assign pkt_i.tready = !full_q || (pkt_o.tready && atFin);
  assign inHs         = pkt_i.tvalid && pkt_i.tready;
  assign outHs        = full_q && pkt_o.tready;

  always_comb begin
    data_d = data_q;
    keep_d = keep_q;
    strb_d = strb_q;
    last_d = last_q;
    id_d   = id_q;
    dest_d = dest_q;
    user_d = user_q;
    idx_d  = idx_q;
    full_d = full_q;
    if (inHs) begin
      data_d = pkt_i.tdata;
      keep_d = pkt_i.tkeep;
      strb_d = pkt_i.tstrb;
      last_d = pkt_i.tlast;
      id_d   = pkt_i.tid;
      dest_d = pkt_i.tdest;
      user_d = pkt_i.tuser;
      idx_d  = '0;
      full_d = 1'b1;
    end else if (outHs) begin
      if (atFin) begin
        idx_d  = '0;
        full_d = 1'b0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q <= '0;
      keep_q <= '0;
      strb_q <= '0;
      last_q <= 1'b0;
      id_q   <= '0;
      dest_q <= '0;
      user_q <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      keep_q <= keep_d;
      strb_q <= strb_d;
      last_q <= last_d;
      id_q   <= id_d;
      dest_q <= dest_d;
      user_q <= user_d;
      idx_q  <= idx_d;
      full_q <= full_d;
    end
  end

  // Every output comes straight from the holding register, never from pkt_i.
  assign pkt_o.tvalid = full_q;
  assign pkt_o.tdata  = dataWords[idx_q];
  assign pkt_o.tkeep  = keepWords[idx_q];
  assign pkt_o.tstrb  = strbWords[idx_q];
  assign pkt_o.tlast  = last_q && atFin;
  assign pkt_o.tid    = id_q;
  assign pkt_o.tdest  = dest_q;
  assign pkt_o.tuser  = user_q;

endmodule

// File: tb/tb_axi4_stream_downsizer.sv
// Randomised bench for the 64->16 downsizer against a queue-based word model.
// Expectations follow AXI4_STREAM_DOWNSIZER_TRIM_EN when it is defined.
module tb_axi4_stream_downsizer;
  localparam int RX_W  = 64;
  localparam int TX_W  = 16;
  localparam int RATIO = RX_W / TX_W;
  localparam int TX_B  = TX_W / 8;

  typedef struct {
    logic [15:0] data;
    logic [1:0]  keep;
    logic [1:0]  strb;
    logic        last;
    logic [2:0]  side;
  } word_t;

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  logic randReady = 1'b0;
  int   testsRun = 0;
  int   testsFailed = 0;
  int   cycle = 0;
  int   outCycles[$];
  word_t expQ[$];

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  axi4_stream_if #(.DATA_WIDTH(RX_W)) rxIf ();
  axi4_stream_if #(.DATA_WIDTH(TX_W)) txIf ();

  axi4_stream_downsizer #(
    .RX_TDATA_WIDTH (RX_W),
    .TX_TDATA_WIDTH (TX_W),
    .TID_WIDTH      (1),
    .TDEST_WIDTH    (1),
    .TUSER_WIDTH    (1)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rstN),
    .pkt_i   (rxIf.slave),
    .pkt_o   (txIf.master)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Model: cut the beat into 16-bit words by shifting; trimming counts populated words.
  task automatic modelBeat(input logic [63:0] d, input logic [7:0] k, input logic [7:0] s,
                           input logic l, input logic [2:0] side);
    int n;
    word_t e;
    n = RATIO;
`ifdef AXI4_STREAM_DOWNSIZER_TRIM_EN
    if (l) begin
      n = 1;
      for (int w = 0; w < RATIO; w++) begin
        if (((k >> (w * TX_B)) & 8'h03) != 8'h00) n = w + 1;
      end
    end
`endif
    for (int w = 0; w < n; w++) begin
      e.data = 16'(d >> (w * TX_W));
      e.keep = 2'(k >> (w * TX_B));
      e.strb = 2'(s >> (w * TX_B));
      e.last = l && (w == n - 1);
      e.side = side;
      expQ.push_back(e);
    end
  endtask

  // Output ready: always high, or a fair coin when randReady is set.
  initial begin
    txIf.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      txIf.tready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compare handshaken words to the model and check stall stability.
  initial begin
    logic        prevStall;
    logic [23:0] prevVec;
    logic [23:0] curVec;
    word_t       e;
    prevStall = 1'b0;
    prevVec   = '0;
    forever begin
      @(negedge clk);
      curVec = {txIf.tdata, txIf.tkeep, txIf.tstrb, txIf.tlast, txIf.tid, txIf.tdest, txIf.tuser};
      if (rstN !== 1'b1) begin
        prevStall = 1'b0;
      end else begin
        if (prevStall) begin
          checkOutput("stallValid", 64'(txIf.tvalid), 64'd1);
          checkOutput("stallOutputs", 64'(curVec), 64'(prevVec));
        end
        if (txIf.tvalid && txIf.tready) begin
          outCycles.push_back(cycle);
          if (expQ.size() == 0) begin
            checkOutput("unexpectedWord", 64'd1, 64'd0);
          end else begin
            e = expQ.pop_front();
            checkOutput("wordData", 64'(txIf.tdata), 64'(e.data));
            checkOutput("wordKeep", 64'(txIf.tkeep), 64'(e.keep));
            checkOutput("wordStrb", 64'(txIf.tstrb), 64'(e.strb));
            checkOutput("wordLast", 64'(txIf.tlast), 64'(e.last));
            checkOutput("wordSide", 64'({txIf.tid, txIf.tdest, txIf.tuser}), 64'(e.side));
          end
        end
        if (rxIf.tvalid && rxIf.tready) begin
          modelBeat(rxIf.tdata, rxIf.tkeep, rxIf.tstrb, rxIf.tlast,
                    {rxIf.tid, rxIf.tdest, rxIf.tuser});
        end
        prevStall = txIf.tvalid && !txIf.tready;
        prevVec   = curVec;
      end
    end
  end

  task automatic applyStimulus(input logic [63:0] d, input logic [7:0] k, input logic l,
                               input logic [2:0] side, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    rxIf.tdata  = d;
    rxIf.tkeep  = k;
    rxIf.tstrb  = k;
    rxIf.tlast  = l;
    rxIf.tid    = side[2];
    rxIf.tdest  = side[1];
    rxIf.tuser  = side[0];
    rxIf.tvalid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (rxIf.tready) done = 1'b1;
      @(posedge clk);
      #1;
      if (!done) begin
        waits++;
        if (waits > 200) begin
          checkOutput("acceptTimeout", 64'(waits), 64'd0);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic idleIn();
    rxIf.tvalid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checkOutput("drainPending", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    checkOutput("globalTimeout", 64'd1, 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    int waits;
    int w2;
    int w3;
    int acceptCycle;
    int expWords;
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;

    rxIf.tvalid = 1'b0;
    rxIf.tdata  = '0;
    rxIf.tkeep  = '0;
    rxIf.tstrb  = '0;
    rxIf.tlast  = 1'b0;
    rxIf.tid    = 1'b0;
    rxIf.tdest  = 1'b0;
    rxIf.tuser  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rstValid", 64'(txIf.tvalid), 64'd0);
    checkOutput("rstLast", 64'(txIf.tlast), 64'd0);
    checkOutput("rstOutputs", 64'({txIf.tdata, txIf.tkeep, txIf.tstrb, txIf.tid, txIf.tdest, txIf.tuser}), 64'd0);
    checkOutput("rstReady", 64'(rxIf.tready), 64'd1);
    @(posedge clk);
    #1;
    rstN = 1'b1;

    // Single full beat, words on four consecutive cycles
    outCycles.delete();
    applyStimulus(64'h4444_3333_2222_1111, 8'hFF, 1'b1, 3'b101, waits);
    acceptCycle = cycle;
    idleIn();
    checkOutput("firstAcceptWaits", 64'(waits), 64'd0);
    waitDrain();
    checkOutput("t1Words", 64'(outCycles.size()), 64'd4);
    if (outCycles.size() == 4) begin
      checkOutput("t1Latency", 64'(outCycles[0]), 64'(acceptCycle));
      checkOutput("t1Consecutive", 64'(outCycles[3] - outCycles[0]), 64'd3);
    end

    // Three back-to-back beats, no output bubble
    outCycles.delete();
    applyStimulus({$urandom, $urandom}, 8'hFF, 1'b0, 3'b010, waits);
    applyStimulus({$urandom, $urandom}, 8'hFF, 1'b0, 3'b011, w2);
    applyStimulus({$urandom, $urandom}, 8'hFF, 1'b1, 3'b100, w3);
    idleIn();
    waitDrain();
    checkOutput("t2Wait2", 64'(w2), 64'd3);
    checkOutput("t2Wait3", 64'(w3), 64'd3);
    checkOutput("t2Words", 64'(outCycles.size()), 64'd12);
    if (outCycles.size() == 12) begin
      checkOutput("t2NoBubble", 64'(outCycles[11] - outCycles[0]), 64'd11);
    end

    // Partial keep on a tlast beat, then an all-null tlast beat
`ifdef AXI4_STREAM_DOWNSIZER_TRIM_EN
    expWords = 2;
`else
    expWords = 4;
`endif
    outCycles.delete();
    applyStimulus(64'h0123_4567_89AB_CDEF, 8'h0F, 1'b1, 3'b001, waits);
    idleIn();
    waitDrain();
    checkOutput("t3PartialWords", 64'(outCycles.size()), 64'(expWords));
`ifdef AXI4_STREAM_DOWNSIZER_TRIM_EN
    expWords = 1;
`else
    expWords = 4;
`endif
    outCycles.delete();
    applyStimulus(64'hFEDC_BA98_7654_3210, 8'h00, 1'b1, 3'b110, waits);
    idleIn();
    waitDrain();
    checkOutput("t3NullWords", 64'(outCycles.size()), 64'(expWords));

    // Random beats under random backpressure
    randReady = 1'b1;
    for (int i = 0; i < 100; i++) begin
      d = {$urandom, $urandom};
      l = ($urandom_range(0, 3) == 0);
      k = l ? 8'($urandom) : 8'hFF;
      applyStimulus(d, k, l, 3'($urandom), waits);
      if ($urandom_range(0, 2) == 0) begin
        idleIn();
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    idleIn();
    waitDrain();
    randReady = 1'b0;
    @(posedge clk);
    #1;

    // Reset while the third word is on the output
    outCycles.delete();
    applyStimulus(64'hDDDD_CCCC_BBBB_AAAA, 8'hFF, 1'b1, 3'b111, waits);
    idleIn();
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("t5PreResetWord", 64'(txIf.tdata), 64'hCCCC);
    rstN = 1'b0;
    expQ.delete();
    #2;
    checkOutput("t5RstValid", 64'(txIf.tvalid), 64'd0);
    checkOutput("t5RstReady", 64'(rxIf.tready), 64'd1);
    checkOutput("t5RstData", 64'(txIf.tdata), 64'd0);
    @(posedge clk);
    #1;
    outCycles.delete();
    rstN = 1'b1;
    applyStimulus(64'h8888_7777_6666_5555, 8'hFF, 1'b1, 3'b010, waits);
    idleIn();
    checkOutput("t5AcceptWaits", 64'(waits), 64'd0);
    waitDrain();
    checkOutput("t5Words", 64'(outCycles.size()), 64'd4);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
